// File: rtl/ddr_burst_arbiter_pkg.sv
// ddr_burst_arbiter_pkg: shared arbiter FSM states, arbitration modes and clog2 helper
package ddr_burst_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} arb_state_e;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/ddr_ch_addr_gen.sv
// ddr_ch_addr_gen: per-channel burst address, ping-pong bank and frame-end tracking
module ddr_ch_addr_gen #(
  parameter int ADDR_W = 25,
  parameter int LEN_W = 10,
  parameter logic [ADDR_W-1:0] BANK_OFS = 25'h0100000
) (
  input  logic clk_ref,
  input  logic rst,
  input  logic load,
  input  logic valid,
  input  logic pingpong,
  input  logic busy,
  input  logic done,
  input  logic [LEN_W-1:0] len,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] max,
  output logic [ADDR_W-1:0] addr,
  output logic bank,
  output logic frame_done,
  output logic frame_pulse
);
  logic load_q, stale_q, stale_d, bank_q, bank_d, fd_q, fd_d, fp_q, fp_d, load_flag;
  logic [ADDR_W-1:0] addr_q, addr_d, cur_base, alt_base;
  logic [ADDR_W:0] nxt, end_a;
  assign load_flag = load && !load_q;
  assign cur_base = base + (bank_q ? BANK_OFS : '0);
  assign alt_base = base + (bank_q ? '0 : BANK_OFS);
  assign nxt = {1'b0, addr_q} + {{(ADDR_W+1-LEN_W){1'b0}}, len};
  assign end_a = {1'b0, max} + (bank_q ? {1'b0, BANK_OFS} : '0);
  // a reload or valid drop while granted makes the in-flight burst's completion stale
  always_comb begin
    addr_d = addr_q;
    bank_d = bank_q;
    fd_d = fd_q;
    fp_d = 1'b0;
    stale_d = busy && (stale_q || load_flag || !valid);
    if (load_flag || !valid) begin
      addr_d = cur_base;
      fd_d = 1'b0;
    end else if (done && !stale_q) begin
      if (nxt < end_a) begin
        addr_d = nxt[ADDR_W-1:0];
      end else begin
        fp_d = 1'b1;
        bank_d = bank_q ^ pingpong;
        addr_d = pingpong ? alt_base : addr_q;
        fd_d = !pingpong;
      end
    end
  end
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      load_q <= 1'b0;
      stale_q <= 1'b0;
      bank_q <= 1'b0;
      fd_q <= 1'b0;
      fp_q <= 1'b0;
      addr_q <= '0;
    end else begin
      load_q <= load;
      stale_q <= stale_d;
      bank_q <= bank_d;
      fd_q <= fd_d;
      fp_q <= fp_d;
      addr_q <= addr_d;
    end
  end
  assign addr = addr_q;
  assign bank = bank_q;
  assign frame_done = fd_q;
  assign frame_pulse = fp_q;
endmodule

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: N-channel DDR burst scheduler; picks an eligible channel and issues one burst at a time
module ddr_burst_arbiter
  import ddr_burst_arbiter_pkg::*;
#(
  parameter int NCH = 4,
  parameter logic [NCH-1:0] WR_MASK = 'b0011,
  parameter int ADDR_W = 25,
  parameter int LEN_W = 10,
  parameter int LVL_W = 10,
  parameter int ARB_MODE = ARB_FIXED,
  parameter logic [ADDR_W-1:0] BANK_OFS = 25'h0100000,
  localparam int CW = clog2(NCH)
) (
  input  logic clk_ref,
  input  logic rst,
  input  logic ddr_init_done,
  input  logic [NCH*LEN_W-1:0] ch_len,
  input  logic [NCH*ADDR_W-1:0] ch_base,
  input  logic [NCH*ADDR_W-1:0] ch_max,
  input  logic [NCH-1:0] ch_pingpong,
  input  logic [NCH-1:0] ch_load,
  input  logic [NCH-1:0] ch_valid,
  input  logic [NCH*LVL_W-1:0] fifo_level,
  output logic cmd_valid,
  input  logic cmd_ready,
  output logic cmd_wr,
  output logic [CW-1:0] cmd_ch,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0] cmd_len,
  input  logic cmd_done,
  output logic [NCH-1:0] frame_done,
  output logic [NCH-1:0] frame_pulse,
  output logic [NCH-1:0] ch_bank
);
  arb_state_e state_q, state_d;
  logic [CW-1:0] gnt_q, gnt_d, rr_q, rr_d, pick;
  logic wr_q, wr_d, found;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] ch_addr [NCH];
  logic [LEN_W-1:0] len_a [NCH];
  logic [NCH-1:0] elig, cls;
  int idx;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic busy;
    assign len_a[c] = ch_len[c*LEN_W +: LEN_W];
    assign busy = (state_q != ST_IDLE) && (gnt_q == CW'(c));
    assign elig[c] = ddr_init_done && ch_valid[c] && !frame_done[c] && !busy &&
      (WR_MASK[c] ? 32'(fifo_level[c*LVL_W +: LVL_W]) >= 32'(len_a[c])
                  : 32'(fifo_level[c*LVL_W +: LVL_W]) < 32'(len_a[c]));
    ddr_ch_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .BANK_OFS(BANK_OFS)) u_gen (
      .clk_ref(clk_ref),
      .rst(rst),
      .load(ch_load[c]),
      .valid(ch_valid[c]),
      .pingpong(ch_pingpong[c]),
      .busy(busy),
      .done(cmd_done && state_q == ST_WAIT && gnt_q == CW'(c)),
      .len(len_a[c]),
      .base(ch_base[c*ADDR_W +: ADDR_W]),
      .max(ch_max[c*ADDR_W +: ADDR_W]),
      .addr(ch_addr[c]),
      .bank(ch_bank[c]),
      .frame_done(frame_done[c]),
      .frame_pulse(frame_pulse[c])
    );
  end
  // write channels form the higher class; the scan start rotates only in round-robin mode
  always_comb begin
    cls = |(elig & WR_MASK) ? (elig & WR_MASK) : (elig & ~WR_MASK);
    pick = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = ((ARB_MODE == ARB_RR ? int'(rr_q) : 0) + k) % NCH;
      if (!found && cls[CW'(idx)]) begin
        found = 1'b1;
        pick = CW'(idx);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    wr_d = wr_q;
    addr_d = addr_q;
    len_d = len_q;
    rr_d = rr_q;
    case (state_q)
      ST_IDLE: if (found) begin
        state_d = ST_ISSUE;
        gnt_d = pick;
        wr_d = WR_MASK[pick];
        addr_d = ch_addr[pick];
        len_d = len_a[pick];
      end
      ST_ISSUE: if (cmd_ready) begin
        state_d = ST_WAIT;
        rr_d = (gnt_q == CW'(NCH-1)) ? '0 : gnt_q + CW'(1);
      end
      ST_WAIT: state_d = cmd_done ? ST_IDLE : ST_WAIT;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q <= '0;
      rr_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      len_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rr_q <= rr_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      len_q <= len_d;
    end
  end
  assign cmd_valid = state_q == ST_ISSUE;
  assign cmd_wr = wr_q;
  assign cmd_ch = gnt_q;
  assign cmd_addr = addr_q;
  assign cmd_len = len_q;
endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// tb_ddr_burst_arbiter: table vectors, directed corner sequences and a randomized transaction-level model
module tb_ddr_burst_arbiter;
  localparam logic [24:0] OFS = 25'h0100000;
  logic clk_ref = 1'b0;
  logic rst = 1'b1;
  logic ddr_init_done = 1'b0;
  logic [39:0] ch_len;
  logic [99:0] ch_base, ch_max;
  logic [3:0] ch_pingpong = '0, ch_load = '0, ch_valid = '0;
  logic [39:0] fifo_level;
  logic cmd_valid, cmd_ready = 1'b0, cmd_wr, cmd_done = 1'b0;
  logic [1:0] cmd_ch;
  logic [24:0] cmd_addr;
  logic [9:0] cmd_len;
  logic [3:0] frame_done, frame_pulse, ch_bank;
  logic [3:0] wrm = 4'b0011;
  int len_a [4], base_a [4], max_a [4], lvl_a [4];
  int n_chk = 0, n_err = 0;
  longint m_addr [4];
  bit m_bank [4], m_fd [4];
  int m_rr;
  always #5 clk_ref = ~clk_ref;
  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign ch_len[g*10 +: 10] = 10'(len_a[g]);
    assign ch_base[g*25 +: 25] = 25'(base_a[g]);
    assign ch_max[g*25 +: 25] = 25'(max_a[g]);
    assign fifo_level[g*10 +: 10] = 10'(lvl_a[g]);
  end
  ddr_burst_arbiter #(.NCH(4), .WR_MASK(4'b0011), .ADDR_W(25), .LEN_W(10), .LVL_W(10),
                      .ARB_MODE(1), .BANK_OFS(OFS)) dut (
    .clk_ref(clk_ref), .rst(rst), .ddr_init_done(ddr_init_done), .ch_len(ch_len),
    .ch_base(ch_base), .ch_max(ch_max), .ch_pingpong(ch_pingpong), .ch_load(ch_load),
    .ch_valid(ch_valid), .fifo_level(fifo_level), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_ch(cmd_ch), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done),
    .frame_done(frame_done), .frame_pulse(frame_pulse), .ch_bank(ch_bank));
  typedef struct packed {
    logic init;
    logic [3:0] valid;
    logic [9:0] l0, l1, l2, l3;
    logic exp_v;
    logic [1:0] exp_ch;
  } vec_t;
  vec_t vt [10];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_ref);
    @(negedge clk_ref);
  endtask
  task automatic reset_dut();
    rst = 1'b1;
    cmd_ready = 1'b0;
    cmd_done = 1'b0;
    ch_load = '0;
    ch_valid = '0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask
  task automatic wait_cmd(input string name);
    int n;
    n = 0;
    while (!cmd_valid && n < 40) begin
      step();
      n++;
    end
    check({name, "_arrive"}, 64'(cmd_valid), 64'(1));
  endtask
  task automatic accept_done();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    step();
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
  endtask
  task automatic cfg(input int len, input int b1, input int b2, input int b3, input int span);
    for (int i = 0; i < 4; i++) begin
      len_a[i] = len;
      lvl_a[i] = 0;
    end
    base_a[0] = 0;
    base_a[1] = b1;
    base_a[2] = b2;
    base_a[3] = b3;
    for (int i = 0; i < 4; i++) max_a[i] = base_a[i] + span;
    ch_pingpong = '0;
  endtask
  task automatic mstep();
    step();
    for (int i = 0; i < 4; i++) if (!ch_valid[i]) begin
      m_addr[i] = base_a[i] + (m_bank[i] ? longint'(OFS) : 0);
      m_fd[i] = 1'b0;
    end
  endtask
  function automatic int pick_model();
    for (int c = 1; c >= 0; c--) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_rr + k) % 4;
        if (int'(wrm[i]) == c && ddr_init_done && ch_valid[i] && !m_fd[i] &&
            (wrm[i] ? lvl_a[i] >= len_a[i] : lvl_a[i] < len_a[i])) return i;
      end
    end
    return -1;
  endfunction
  initial begin
    logic seen;
    logic [3:0] exp_fp, mb, mf;
    int w;
    bit acc;
    vt[0] = '{1'b0, 4'b1111, 10'd300, 10'd300, 10'd0, 10'd0, 1'b0, 2'd0};
    vt[1] = '{1'b1, 4'b0000, 10'd300, 10'd300, 10'd0, 10'd0, 1'b0, 2'd0};
    vt[2] = '{1'b1, 4'b0001, 10'd255, 10'd0, 10'd0, 10'd0, 1'b0, 2'd0};
    vt[3] = '{1'b1, 4'b0001, 10'd256, 10'd0, 10'd0, 10'd0, 1'b1, 2'd0};
    vt[4] = '{1'b1, 4'b0010, 10'd0, 10'd600, 10'd0, 10'd0, 1'b1, 2'd1};
    vt[5] = '{1'b1, 4'b0100, 10'd0, 10'd0, 10'd0, 10'd0, 1'b1, 2'd2};
    vt[6] = '{1'b1, 4'b0100, 10'd0, 10'd0, 10'd256, 10'd0, 1'b0, 2'd0};
    vt[7] = '{1'b1, 4'b0110, 10'd0, 10'd256, 10'd0, 10'd0, 1'b1, 2'd1};
    vt[8] = '{1'b1, 4'b1100, 10'd0, 10'd0, 10'd10, 10'd10, 1'b1, 2'd2};
    vt[9] = '{1'b1, 4'b1001, 10'd100, 10'd0, 10'd0, 10'd255, 1'b1, 2'd3};
    cfg(256, 'h1000, 'h2000, 'h3000, 'h4000);
    reset_dut();
    check("reset_state", 64'({cmd_valid, cmd_wr, cmd_ch, cmd_addr, cmd_len, frame_done, frame_pulse, ch_bank}), 64'(0));
    for (int v = 0; v < 10; v++) begin
      reset_dut();
      ddr_init_done = vt[v].init;
      ch_valid = vt[v].valid;
      lvl_a[0] = int'(vt[v].l0);
      lvl_a[1] = int'(vt[v].l1);
      lvl_a[2] = int'(vt[v].l2);
      lvl_a[3] = int'(vt[v].l3);
      step();
      step();
      check($sformatf("vec%0d_valid", v), 64'(cmd_valid), 64'(vt[v].exp_v));
      if (vt[v].exp_v)
        check($sformatf("vec%0d_cmd", v), 64'({cmd_ch, cmd_wr, cmd_addr}),
              64'({vt[v].exp_ch, wrm[vt[v].exp_ch], 25'(base_a[vt[v].exp_ch])}));
    end
    cfg(256, 0, 0, 0, 1024);
    reset_dut();
    ddr_init_done = 1'b1;
    ch_valid = 4'b0001;
    lvl_a[0] = 256;
    for (int k = 0; k < 4; k++) begin
      wait_cmd("wl");
      check("wl_cmd", 64'({cmd_ch, cmd_wr, cmd_addr, cmd_len}), 64'({2'd0, 1'b1, 25'(k * 256), 10'd256}));
      accept_done();
    end
    check("wl_frame", 64'({frame_done, frame_pulse}), 64'({4'b0001, 4'b0001}));
    seen = 1'b0;
    repeat (8) begin
      step();
      seen |= cmd_valid;
    end
    check("wl_stop", 64'(seen), 64'(0));
    cfg(256, 'h1000, 'h2000, 'h3000, 'h10000);
    reset_dut();
    ch_valid = 4'b0111;
    lvl_a[0] = 300;
    lvl_a[1] = 300;
    for (int k = 0; k < 4; k++) begin
      wait_cmd("rr");
      check($sformatf("rr_grant%0d", k), 64'({cmd_ch, cmd_wr}), 64'({2'(k % 2), 1'b1}));
      accept_done();
    end
    lvl_a[0] = 100;
    lvl_a[1] = 100;
    wait_cmd("rd");
    check("rd_grant", 64'({cmd_ch, cmd_wr, cmd_addr}), 64'({2'd2, 1'b0, 25'h2000}));
    accept_done();
    cfg(256, 0, 0, 0, 512);
    ch_pingpong = 4'b0010;
    reset_dut();
    ch_valid = 4'b0010;
    lvl_a[1] = 256;
    for (int k = 0; k < 2; k++) begin
      wait_cmd("pp");
      check("pp_addr", 64'({cmd_ch, cmd_addr}), 64'({2'd1, 25'(k * 256)}));
      accept_done();
    end
    check("pp_end", 64'({frame_pulse[1], ch_bank[1], frame_done[1]}), 64'(3'b110));
    wait_cmd("pp_bank1");
    check("pp_bank1_addr", 64'(cmd_addr), 64'(OFS));
    check("pp_pulse_clr", 64'(frame_pulse), 64'(0));
    for (int k = 0; k < 10; k++) begin
      step();
      check("bp_hold", 64'({cmd_valid, cmd_ch, cmd_addr, cmd_len}), 64'({1'b1, 2'd1, OFS, 10'd256}));
    end
    accept_done();
    wait_cmd("pp_next");
    check("pp_next_addr", 64'(cmd_addr), 64'(OFS + 25'd256));
    rst = 1'b1;
    step();
    check("rst_issue", 64'({cmd_valid, frame_done, ch_bank}), 64'(0));
    rst = 1'b0;
    cfg(256, 0, 0, 0, 1024);
    reset_dut();
    ch_valid = 4'b0001;
    lvl_a[0] = 256;
    for (int k = 0; k < 3; k++) begin
      wait_cmd("rl");
      check("rl_addr", 64'(cmd_addr), 64'(k * 256));
      if (k < 2) accept_done();
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    ch_load = 4'b0001;
    step();
    ch_load = '0;
    step();
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    wait_cmd("rl_after");
    check("rl_reload_addr", 64'({cmd_ch, cmd_addr}), 64'(0));
    accept_done();
    ch_valid = '0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) lvl_a[i] = k * 400;
      seen = 1'b0;
      repeat (5) begin
        step();
        seen |= cmd_valid;
      end
      check("valid_gate", 64'(seen), 64'(0));
    end
    for (int i = 0; i < 4; i++) begin
      len_a[i] = $urandom_range(1, 300);
      base_a[i] = $urandom_range(0, 4095) * 16;
      max_a[i] = base_a[i] + $urandom_range(1, 1200);
    end
    ch_pingpong = 4'($urandom);
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      m_addr[i] = base_a[i];
      m_bank[i] = 1'b0;
      m_fd[i] = 1'b0;
    end
    m_rr = 0;
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < 4; i++) begin
        lvl_a[i] = $urandom_range(0, 400);
        ch_valid[i] = ($urandom % 5) != 0;
      end
      ddr_init_done = ($urandom % 10) != 0;
      w = pick_model();
      if (w < 0) begin
        seen = 1'b0;
        repeat (4) begin
          mstep();
          seen |= cmd_valid;
        end
        check("rnd_idle", 64'(seen), 64'(0));
        continue;
      end
      mstep();
      check("rnd_grant", 64'({cmd_valid, cmd_ch, cmd_wr, cmd_addr, cmd_len}),
            64'({1'b1, 2'(w), wrm[w], 25'(m_addr[w]), 10'(len_a[w])}));
      for (int k = 0; k < 30; k++) begin
        cmd_ready = (k == 29) || ($urandom % 2 == 1);
        acc = cmd_ready;
        mstep();
        if (acc) break;
        check("rnd_hold", 64'({cmd_valid, cmd_ch, cmd_addr, cmd_len}),
              64'({1'b1, 2'(w), 25'(m_addr[w]), 10'(len_a[w])}));
      end
      cmd_ready = 1'b0;
      m_rr = (w + 1) % 4;
      repeat ($urandom_range(0, 2)) mstep();
      cmd_done = 1'b1;
      mstep();
      cmd_done = 1'b0;
      exp_fp = '0;
      if (m_addr[w] + len_a[w] < max_a[w] + (m_bank[w] ? longint'(OFS) : 0)) begin
        m_addr[w] = m_addr[w] + len_a[w];
      end else begin
        exp_fp[w] = 1'b1;
        if (ch_pingpong[w]) begin
          m_bank[w] = !m_bank[w];
          m_addr[w] = base_a[w] + (m_bank[w] ? longint'(OFS) : 0);
        end else begin
          m_fd[w] = 1'b1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        mb[i] = m_bank[i];
        mf[i] = m_fd[i];
      end
      check("rnd_done", 64'({frame_pulse, ch_bank, frame_done}), 64'({exp_fp, mb, mf}));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ddr_burst_arbiter.md
Name: ddr_burst_arbiter

Overview:
- Single-clock, N-channel DDR burst scheduler and address generator; the multi-channel successor to the two-port write/read FIFO controller.
- Watches per-channel FIFO fill levels, already synchronised into clk_ref by the owning FIFOs.
- Picks one eligible channel (fixed priority or round-robin), issues one burst command, and advances that channel's address on completion.
- Adds per-channel ping-pong frame banking, so write and read of one frame store can run on alternate buffers.

Parameters:
NCH, 4, number of channels (2..8)
WR_MASK, 4'b0011, bit i=1: channel i is a write channel (FIFO->DDR); 0: read channel (DDR->FIFO)
ADDR_W, 25, DDR word address width
LEN_W, 10, burst length width
LVL_W, 10, FIFO level width
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
BANK_OFS, 25'h0100000, address offset of bank 1 relative to bank 0

Ports:
clk_ref  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
ddr_init_done  in  1  no command is issued while low
ch_len  in  NCH*LEN_W  per-channel burst length (non-zero)
ch_base  in  NCH*ADDR_W  per-channel bank-0 base address
ch_max  in  NCH*ADDR_W  per-channel bank-0 end address (exclusive)
ch_pingpong  in  NCH  enable bank toggle at frame end
ch_load  in  NCH  rising edge reloads the channel
ch_valid  in  NCH  low = channel idle; address held at base of current bank
fifo_level  in  NCH*LVL_W  write ch: words stored; read ch: words stored
cmd_valid  out  1  command valid
cmd_ready  in  1  DDR controller accepts the command
cmd_wr  out  1  1 = write burst, 0 = read burst
cmd_ch  out  clog2(NCH)  channel index
cmd_addr  out  ADDR_W  burst start address
cmd_len  out  LEN_W  burst length
cmd_done  in  1  one-cycle pulse when the outstanding burst finishes
frame_done  out  NCH  sticky; set on last burst of a frame
frame_pulse  out  NCH  one-cycle pulse at frame end
ch_bank  out  NCH  current bank per channel

Behaviour:
- Reset values: all outputs 0. Per-channel addresses = 0, banks = 0. Arbiter in IDLE. Round-robin pointer = 0.
- Load: ch_load is registered once; load_flag = rising edge. On load_flag: addr <= base + bank*BANK_OFS, frame_done <= 0. Bank is not changed.
- Valid: while ch_valid=0, addr is held at the bank base and frame_done = 0. Load has priority over valid, and valid over cmd_done.
- Eligibility requires all of: ddr_init_done, ch_valid, !frame_done, channel not currently granted.
  - Write channel: additionally level >= len.
  - Read channel: additionally level < len.
- Priority between classes: write channels always beat read channels. ARB_MODE applies only within a class.
- Arbiter FSM, one outstanding command:
  - IDLE: if any channel is eligible, latch ch/wr/addr/len and go to ISSUE.
  - ISSUE: cmd_valid=1 with fields stable until cmd_ready. The handshake cycle moves to WAIT.
  - WAIT: on cmd_done, update the address and go to IDLE.
- Minimum spacing between two commands is 3 cycles. Round-robin pointer becomes granted+1 mod NCH when the command is accepted.
- Address update on cmd_done, for the granted channel, computed in ADDR_W+1 bits so max < len cannot underflow:
  - If addr + len < end: addr += len.
  - Else (frame end): frame_pulse=1 for 1 cycle.
    - ch_pingpong=1: bank toggles, addr <= new bank base, frame_done stays 0.
    - ch_pingpong=0: addr held, frame_done <= 1.
  - end = max + bank*BANK_OFS.
- Mid-command load or valid drop on the granted channel: the command still completes. Its cmd_done causes no address or frame update. load_flag in the same cycle as cmd_done: load wins.
- cmd_done seen in IDLE or ISSUE is ignored.
- rst asserted at any time: back to reset values next cycle, and any in-flight command is abandoned.

Decomposition:
- Shared package: FSM state encoding (IDLE/ISSUE/WAIT), ARB_MODE constants, clog2 function.
- Sub-module ddr_ch_addr_gen, one instance per channel: load edge detect, address, bank, frame_done/pulse. The top holds the arbiter and FSM.

Test Plan:
- Write level: NCH=4, ch0 write len=256 base=0 max=1024, level=256 -> cmd at addr 0, 256, 512, 768. After the 4th cmd_done, frame_done[0]=1 and no further commands.
- Class priority and round-robin: ARB_MODE=1, ch0 and ch1 write both level=300, ch2 read level=0, cmd_ready=1 and cmd_done 2 cycles after each accept. Grants run 0,1,0,1…. Ch2 is granted only after both write levels drop below 256.
- Ping-pong: ch1 pingpong=1, max=512, len=256. After 2 bursts: frame_pulse[1]=1 and ch_bank[1]=1. The next cmd_addr = 0x100000 and frame_done[1] stays 0.
- Backpressure: hold cmd_ready=0 for 10 cycles -> cmd_valid=1 with cmd_addr, cmd_len and cmd_ch constant throughout.
- Mid-command reload: pulse ch_load[0] while in WAIT, addr 512 -> after cmd_done, next cmd_addr for ch0 = 0. Also check valid-low gating: ch_valid=0 -> no grant at any level.
- Reset: assert rst during ISSUE -> next cycle cmd_valid=0, all frame_done=0, all banks=0.
